// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the 4-stage pipeline sequencing controller.
// State encoding, the IF/ID NOP word and the default register-address width.
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_LDSTALL = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_HALT    = 3'd3,
    ST_STEP    = 3'd4
  } state_e;

  localparam logic [7:0] NOP_INSTR  = 8'h00;
  localparam int         REG_AW_DEF = 2;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Load-use hazard compare between the ID instruction and a load in EX.
// Purely combinational; also shared with the forwarding unit.
module pipe_hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd,
  output logic              hazard
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
  assign hazard  = id_valid && ex_valid && ex_is_load
                && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: jump flush, load-use stall, mem freeze, debug halt/step.
// Define PIPE_PERF_CNT_EN to build the stall/flush performance counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW         = REG_AW_DEF,
  parameter int LOAD_STALL_CYC = 1,
  parameter int DRAIN_CYC      = 2,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_jump_taken,
  input  logic              mem_busy,
  input  logic              dbg_halt_req,
  input  logic              dbg_step,
  output logic              pc_en,
  output logic              pc_sel,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              pipe_hold,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [3:0] LS_INIT =
    4'((LOAD_STALL_CYC > 1) ? LOAD_STALL_CYC - 2 : 0);
  localparam logic [3:0] DR_INIT = 4'(DRAIN_CYC - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       hazard;
  logic       jump;

  pipe_hazard_detect #(.REG_AW(REG_AW)) u_detect (
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_valid    (ex_valid),
    .ex_is_load  (ex_is_load),
    .ex_rd       (ex_rd),
    .hazard      (hazard)
  );

  assign jump = ex_valid && ex_jump_taken;

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    pc_sel      = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;
    halted      = (state_q == ST_HALT);
    state_d     = state_q;
    cnt_d       = cnt_q;
    if (mem_busy) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      pipe_hold = 1'b1;
    end else if (jump) begin
      pc_sel      = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      // A redirect mid-drain keeps draining toward HALT
      if (state_q != ST_DRAIN && state_q != ST_HALT) begin
        state_d = ST_RUN;
      end
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (hazard) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
            if (LOAD_STALL_CYC > 1) begin
              state_d = ST_LDSTALL;
              cnt_d   = LS_INIT;
            end
          end else if (dbg_halt_req) begin
            state_d = ST_DRAIN;
            cnt_d   = DR_INIT;
          end
        end
        ST_LDSTALL: begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
          if (cnt_q == 4'd0) state_d = ST_RUN;
          else               cnt_d   = cnt_q - 4'd1;
        end
        ST_DRAIN: begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
          if (cnt_q == 4'd0) state_d = ST_HALT;
          else               cnt_d   = cnt_q - 4'd1;
        end
        ST_HALT: begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
          if (!dbg_halt_req) state_d = ST_RUN;
          else if (dbg_step) state_d = ST_STEP;
        end
        ST_STEP: begin
          if (hazard) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
          end
          state_d = ST_DRAIN;
          cnt_d   = DR_INIT;
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = 4'd0;
        end
      endcase
    end
    if (!reset) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      pipe_hold   = 1'b0;
      pc_sel      = 1'b0;
      halted      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic             stall_inc;
  logic             flush_inc;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    flush_inc = !mem_busy && jump;
    stall_inc = !mem_busy && !jump
             && ((hazard && (state_q == ST_RUN || state_q == ST_STEP))
              || state_q == ST_LDSTALL);
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_inc && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then random traffic.
// The reference model tracks remaining stall/drain cycles and halt/step flags.
module tb_pipe_hazard_ctrl;

  localparam int AW  = 2;
  localparam int LSC = 3;
  localparam int DC  = 2;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          id_valid, id_uses_rs1, id_uses_rs2;
  logic [AW-1:0] id_rs1, id_rs2, ex_rd;
  logic          ex_valid, ex_is_load, ex_jump_taken;
  logic          mem_busy, dbg_halt_req, dbg_step;
  logic          pc_en, pc_sel, ifid_en, ifid_flush;
  logic          idex_bubble, pipe_hold, halted;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(
    .REG_AW(AW), .LOAD_STALL_CYC(LSC), .DRAIN_CYC(DC), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .ex_jump_taken(ex_jump_taken), .mem_busy(mem_busy),
    .dbg_halt_req(dbg_halt_req), .dbg_step(dbg_step),
    .pc_en(pc_en), .pc_sel(pc_sel), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .pipe_hold(pipe_hold), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct packed {
    logic [6:0]    ctl;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  int m_stall_left = 0;
  int m_drain_left = 0;
  bit m_halt = 0;
  bit m_step = 0;
  int m_sc = 0;
  int m_fc = 0;

  function automatic void model_push();
    bit   pe, ps, ie, fl, bb, ph, h, hz, jp;
    exp_t e;
    pe = 1; ps = 0; ie = 1; fl = 0; bb = 0; ph = 0; h = 0;
    hz = id_valid && ex_valid && ex_is_load &&
         ((id_uses_rs1 && id_rs1 == ex_rd) ||
          (id_uses_rs2 && id_rs2 == ex_rd));
    jp = ex_valid && ex_jump_taken;
    if (!reset) begin
      m_stall_left = 0; m_drain_left = 0;
      m_halt = 0; m_step = 0; m_sc = 0; m_fc = 0;
      pe = 0; ie = 0; fl = 1; bb = 1;
    end
`ifdef PIPE_PERF_CNT_EN
    e.sc = CW'(m_sc);
    e.fc = CW'(m_fc);
`else
    e.sc = '0;
    e.fc = '0;
`endif
    if (reset) begin
      h = m_halt;
      if (mem_busy) begin
        pe = 0; ie = 0; ph = 1;
      end else if (jp) begin
        ps = 1; fl = 1; bb = 1;
        if (m_fc < SAT) m_fc++;
        if (m_drain_left == 0 && !m_halt) begin
          m_stall_left = 0; m_step = 0;
        end
      end else if (m_stall_left > 0) begin
        pe = 0; ie = 0; bb = 1;
        if (m_sc < SAT) m_sc++;
        m_stall_left--;
      end else if (m_drain_left > 0) begin
        pe = 0; ie = 0; bb = 1;
        m_drain_left--;
        if (m_drain_left == 0) m_halt = 1;
      end else if (m_halt) begin
        pe = 0; ie = 0; bb = 1;
        if (!dbg_halt_req) m_halt = 0;
        else if (dbg_step) begin m_halt = 0; m_step = 1; end
      end else if (m_step) begin
        if (hz) begin
          pe = 0; ie = 0; bb = 1;
          if (m_sc < SAT) m_sc++;
        end
        m_step = 0;
        m_drain_left = DC;
      end else begin
        if (hz) begin
          pe = 0; ie = 0; bb = 1;
          if (m_sc < SAT) m_sc++;
          m_stall_left = LSC - 1;
        end else if (dbg_halt_req) begin
          m_drain_left = DC;
        end
      end
    end
    e.ctl = {pe, ps, ie, fl, bb, ph, h};
    q.push_back(e);
  endfunction

  initial begin
    exp_t e;
    logic [6:0] act;
    forever begin
      @(negedge clk);
      #3;
      while (q.size() > 0) begin
        e   = q.pop_front();
        act = {pc_en, pc_sel, ifid_en, ifid_flush,
               idex_bubble, pipe_hold, halted};
        checks++;
        if (act === e.ctl) passed++;
        else $display("FAIL ctl t=%0t got=%b want=%b", $time, act, e.ctl);
        checks++;
        if (stall_cnt === e.sc && flush_cnt === e.fc) passed++;
        else $display("FAIL cnt t=%0t got=%0d/%0d want=%0d/%0d",
                      $time, stall_cnt, flush_cnt, e.sc, e.fc);
      end
    end
  end

  task automatic go();
    #1;
    model_push();
    @(negedge clk);
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_valid = 0; ex_is_load = 0; ex_rd = 0; ex_jump_taken = 0;
    mem_busy = 0; dbg_step = 0;
  endtask

  task automatic set_hazard();
    ex_valid = 1; ex_is_load = 1; ex_rd = 2'd2;
    id_valid = 1; id_rs1 = 2'd2; id_uses_rs1 = 1;
  endtask

  initial begin
    reset = 0;
    dbg_halt_req = 0;
    idle();
    @(negedge clk);
    go(); go();
    reset = 1;
    go();
    // load-use stall with a 3-cycle memory freeze in the middle
    set_hazard(); go();
    mem_busy = 1; go(); go(); go();
    mem_busy = 0; go(); go();
    idle(); go();
    // jump redirect
    ex_valid = 1; ex_jump_taken = 1; go();
    idle(); go();
    // halt, single step, resume
    dbg_halt_req = 1; go(); go(); go(); go();
    dbg_step = 1; go();
    dbg_step = 0; go(); go(); go(); go();
    dbg_halt_req = 0; go();
    go();
    // jump during drain
    dbg_halt_req = 1; go(); go();
    ex_valid = 1; ex_jump_taken = 1; go();
    idle(); go(); go(); go();
    // reset while halted
    reset = 0; go();
    reset = 1; dbg_halt_req = 0; go(); go();
    for (int i = 0; i < 3000; i++) begin
      reset         = ($urandom_range(0, 199) != 0);
      mem_busy      = ($urandom_range(0, 5) == 0);
      id_valid      = ($urandom_range(0, 3) != 0);
      id_rs1        = AW'($urandom_range(0, 3));
      id_rs2        = AW'($urandom_range(0, 3));
      id_uses_rs1   = $urandom_range(0, 1) == 1;
      id_uses_rs2   = $urandom_range(0, 1) == 1;
      ex_valid      = $urandom_range(0, 1) == 1;
      ex_is_load    = $urandom_range(0, 1) == 1;
      ex_rd         = AW'($urandom_range(0, 3));
      ex_jump_taken = ($urandom_range(0, 7) == 0);
      dbg_step      = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 29) == 0) dbg_halt_req = ~dbg_halt_req;
      go();
    end
    idle();
    go();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain got=%0d want=0", q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
